// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Top-level game sequencer for the Flappy Bird datapath, clocked on the 10 Hz
// game tick. It walks IDLE -> PLAY -> HIT -> OVER -> IDLE, drives the tube
// scroller's clear/freeze inputs, gates bird physics, picks the scroll speed
// from the running score and remembers the best score since reset.
//
// Ports:
//   clk10      in   game tick clock, all logic on posedge
//   clr        in   asynchronous active-low reset
//   btn        in   flap/start button level (already synchronous to clk10)
//   collision  in   bird overlaps a tube or the ground
//   score      in   running score from the tube scroller (8 bit)
//   state      out  00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//   tube_clr   out  active-low clear to the tube scroller
//   game_end   out  freezes the tube scroller when high
//   bird_en    out  enables bird physics
//   speed_lvl  out  scroll speed select, 0..MAX_SPEED
//   high_score out  best score since reset
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int HIT_TICKS  = 10,
    parameter int SPEED_STEP = 10,
    parameter int MAX_SPEED  = 3
) (
    input  logic       clk10,
    input  logic       clr,
    input  logic       btn,
    input  logic       collision,
    input  logic [7:0] score,
    output logic [1:0] state,
    output logic       tube_clr,
    output logic       game_end,
    output logic       bird_en,
    output logic [1:0] speed_lvl,
    output logic [7:0] high_score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [7:0] HIT_LAST  = 8'(HIT_TICKS - 1);
    localparam logic [1:0] SPEED_MAX = 2'(MAX_SPEED);
    localparam logic [9:0] STEP_W    = 10'(SPEED_STEP);

    // Score needed to leave speed level lvl; 10 bits so 3*step cannot wrap.
    function automatic logic [9:0] speed_threshold(input logic [1:0] lvl);
        return STEP_W * ({8'd0, lvl} + 10'd1);
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic       btn_q_r;
    logic       press_s;
    logic [7:0] hit_cnt_r;
    logic [7:0] hit_cnt_nxt_s;
    logic [1:0] speed_r;
    logic [1:0] speed_nxt_s;
    logic [7:0] high_r;
    logic [7:0] high_nxt_s;
    logic       tube_clr_r;
    logic       tube_clr_nxt_s;
    logic       game_end_r;
    logic       game_end_nxt_s;
    logic       bird_en_r;
    logic       bird_en_nxt_s;

    // A held button produces exactly one press on its rising edge.
    assign press_s = btn & ~btn_q_r;

    // Next-state, hit timer and high-score update.
    always_comb begin
        state_nxt_s   = state_r;
        hit_cnt_nxt_s = 8'd0;
        high_nxt_s    = high_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Collision wins over a simultaneous press; a press alone is a
                // flap and is handled by the bird block.
                if (collision) begin
                    state_nxt_s = ST_HIT;
                    if (score > high_r) begin
                        high_nxt_s = score;
                    end else begin
                        high_nxt_s = high_r;
                    end
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_HIT: begin
                // Inputs are ignored while the bird falls.
                if (hit_cnt_r == HIT_LAST) begin
                    state_nxt_s   = ST_OVER;
                    hit_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s   = ST_HIT;
                    hit_cnt_nxt_s = hit_cnt_r + 8'd1;
                end
            end
            ST_OVER: begin
                if (press_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Speed level: one step per tick while playing, zero whenever idle.
    always_comb begin
        speed_nxt_s = speed_r;
        if (state_nxt_s == ST_IDLE) begin
            speed_nxt_s = 2'd0;
        end else if ((state_r == ST_PLAY) && (speed_r < SPEED_MAX) &&
                     ({2'b00, score} >= speed_threshold(speed_r))) begin
            speed_nxt_s = speed_r + 2'd1;
        end else begin
            speed_nxt_s = speed_r;
        end
    end

    // Moore output decode of the upcoming state, so the outputs can be
    // registered alongside the state and still change on the same edge.
    always_comb begin
        tube_clr_nxt_s = 1'b0;
        game_end_nxt_s = 1'b1;
        bird_en_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                tube_clr_nxt_s = 1'b0;
                game_end_nxt_s = 1'b1;
                bird_en_nxt_s  = 1'b0;
            end
            ST_PLAY: begin
                tube_clr_nxt_s = 1'b1;
                game_end_nxt_s = 1'b0;
                bird_en_nxt_s  = 1'b1;
            end
            ST_HIT: begin
                tube_clr_nxt_s = 1'b1;
                game_end_nxt_s = 1'b1;
                bird_en_nxt_s  = 1'b1;
            end
            ST_OVER: begin
                // Tubes stay on screen, bird physics stops.
                tube_clr_nxt_s = 1'b1;
                game_end_nxt_s = 1'b1;
                bird_en_nxt_s  = 1'b0;
            end
            default: begin
                tube_clr_nxt_s = 1'b0;
                game_end_nxt_s = 1'b1;
                bird_en_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; clr forces the IDLE picture.
    always_ff @(posedge clk10 or negedge clr) begin
        if (!clr) begin
            state_r    <= ST_IDLE;
            btn_q_r    <= 1'b0;
            hit_cnt_r  <= 8'd0;
            speed_r    <= 2'd0;
            high_r     <= 8'd0;
            tube_clr_r <= 1'b0;
            game_end_r <= 1'b1;
            bird_en_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            btn_q_r    <= btn;
            hit_cnt_r  <= hit_cnt_nxt_s;
            speed_r    <= speed_nxt_s;
            high_r     <= high_nxt_s;
            tube_clr_r <= tube_clr_nxt_s;
            game_end_r <= game_end_nxt_s;
            bird_en_r  <= bird_en_nxt_s;
        end
    end

    assign state      = state_r;
    assign tube_clr   = tube_clr_r;
    assign game_end   = game_end_r;
    assign bird_en    = bird_en_r;
    assign speed_lvl  = speed_r;
    assign high_score = high_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed table of per-tick {inputs, expected outputs} records covering three
// games (start, speed ramp, score wrap, HIT duration, OVER restart, high-score
// tracking), followed by hand-written sequences for an asynchronous reset in
// the middle of HIT and a bounded count of HIT cycles.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

    logic       clk10;
    logic       clr;
    logic       btn;
    logic       collision;
    logic [7:0] score;
    logic [1:0] state;
    logic       tube_clr;
    logic       game_end;
    logic       bird_en;
    logic [1:0] speed_lvl;
    logic [7:0] high_score;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       btn;
        logic       col;
        logic [7:0] score;
        logic [1:0] st;
        logic       tc;
        logic       ge;
        logic       be;
        logic [1:0] spd;
        logic [7:0] hs;
    } vec_t;

    vec_t vecs[$];

    game_flow_ctrl #(
        .HIT_TICKS (10),
        .SPEED_STEP(10),
        .MAX_SPEED (3)
    ) dut (
        .clk10     (clk10),
        .clr       (clr),
        .btn       (btn),
        .collision (collision),
        .score     (score),
        .state     (state),
        .tube_clr  (tube_clr),
        .game_end  (game_end),
        .bird_en   (bird_en),
        .speed_lvl (speed_lvl),
        .high_score(high_score)
    );

    initial begin
        clk10 = 1'b0;
        forever #5 clk10 = ~clk10;
    end

    task automatic add(input logic b, input logic c, input logic [7:0] s,
                       input logic [1:0] st, input logic tc, input logic ge,
                       input logic be, input logic [1:0] spd, input logic [7:0] hs);
        vec_t v;
        v.btn = b; v.col = c; v.score = s; v.st = st; v.tc = tc;
        v.ge = ge; v.be = be; v.spd = spd; v.hs = hs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic tc,
                             input logic ge, input logic be, input logic [1:0] spd,
                             input logic [7:0] hs);
        check({tag, ".state"},      {6'd0, state},     {6'd0, st});
        check({tag, ".tube_clr"},   {7'd0, tube_clr},  {7'd0, tc});
        check({tag, ".game_end"},   {7'd0, game_end},  {7'd0, ge});
        check({tag, ".bird_en"},    {7'd0, bird_en},   {7'd0, be});
        check({tag, ".speed_lvl"},  {6'd0, speed_lvl}, {6'd0, spd});
        check({tag, ".high_score"}, high_score,        hs);
    endtask

    task automatic step();
        @(posedge clk10);
        #1;
    endtask

    initial begin
        int n;
        int k;
        clr       = 1'b0;
        btn       = 1'b0;
        collision = 1'b0;
        score     = 8'd0;

        // Game 1: held button starts once, speed ramps, collide with press.
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
        add(1'b0, 1'b0, 8'd25, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd0);
        add(1'b0, 1'b0, 8'd25, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd0);
        add(1'b0, 1'b0, 8'd25, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd0);
        add(1'b0, 1'b0, 8'd40, 2'd1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0);
        add(1'b0, 1'b0, 8'd40, 2'd1, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0);
        add(1'b1, 1'b1, 8'd7,  2'd2, 1'b1, 1'b1, 1'b1, 2'd3, 8'd7);
        // Nine more HIT ticks; presses and collision in here are ignored.
        for (int i = 0; i < 9; i++)
            add((i == 1 || i == 3) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 8'd7,
                2'd2, 1'b1, 1'b1, 1'b1, 2'd3, 8'd7);
        add(1'b0, 1'b0, 8'd7, 2'd3, 1'b1, 1'b1, 1'b0, 2'd3, 8'd7);
        add(1'b0, 1'b0, 8'd7, 2'd3, 1'b1, 1'b1, 1'b0, 2'd3, 8'd7);
        // OVER -> IDLE on first press, held button does not start a game.
        add(1'b1, 1'b0, 8'd7, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
        add(1'b1, 1'b0, 8'd7, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
        add(1'b0, 1'b0, 8'd7, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
        // Game 2: collide at 5, high score stays 7.
        add(1'b1, 1'b0, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd7);
        add(1'b0, 1'b0, 8'd5, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd7);
        add(1'b0, 1'b1, 8'd5, 2'd2, 1'b1, 1'b1, 1'b1, 2'd0, 8'd7);
        for (int i = 0; i < 9; i++) add(1'b0, 1'b0, 8'd5, 2'd2, 1'b1, 1'b1, 1'b1, 2'd0, 8'd7);
        add(1'b0, 1'b0, 8'd5, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd7);
        add(1'b1, 1'b0, 8'd5, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
        add(1'b0, 1'b0, 8'd5, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
        // Game 3: score 255 wraps to 0 without lowering speed, collide at 9.
        add(1'b1, 1'b0, 8'd0,   2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd7);
        add(1'b0, 1'b0, 8'd255, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd7);
        add(1'b0, 1'b0, 8'd0,   2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd7);
        add(1'b0, 1'b1, 8'd9,   2'd2, 1'b1, 1'b1, 1'b1, 2'd1, 8'd9);

        // Reset values while clr is held low.
        #12;
        check_all("reset", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk10);
        clr = 1'b1;

        foreach (vecs[i]) begin
            btn       = vecs[i].btn;
            collision = vecs[i].col;
            score     = vecs[i].score;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tc, vecs[i].ge,
                      vecs[i].be, vecs[i].spd, vecs[i].hs);
        end

        // Advance to hit_cnt = 4, then reset without a clock edge.
        btn       = 1'b0;
        collision = 1'b0;
        repeat (4) step();
        check_all("hit_cnt4", 2'd2, 1'b1, 1'b1, 1'b1, 2'd1, 8'd9);
        clr = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk10);
        clr = 1'b1;
        step();
        check_all("post_rst_idle", 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);

        // Fresh game: HIT must last exactly 10 ticks then land in OVER.
        btn = 1'b1;
        step();
        check_all("restart_play", 2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
        btn       = 1'b0;
        collision = 1'b1;
        score     = 8'd3;
        step();
        check_all("restart_hit", 2'd2, 1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
        collision = 1'b0;
        n = 1;
        k = 0;
        while (state == 2'd2 && k < 30) begin
            step();
            k++;
            if (state == 2'd2) n++;
        end
        check("hit_len", 8'(n), 8'd10);
        check_all("restart_over", 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
